// File: rtl/mem_arith_sequencer_if.sv
// Bundle between the multi-byte add/subtract sequencer, its controller and the 256x8 data memory.
// Handshake: start is a one-shot request honoured only while idle (no ready/backpressure); busy is
// high while a job runs, done pulses for one cycle at completion, and carry_out is valid from done
// until the next accepted start. The memory side is async read (mem_rdata follows mem_addr) and
// writes on the rising edge when mem_store is high.
interface mem_arith_sequencer_if #(
    parameter int ADDR_W = 8,
    parameter int DATA_W = 8
);
    logic              start;
    logic              op;
    logic [ADDR_W-1:0] base_a;
    logic [ADDR_W-1:0] base_b;
    logic [ADDR_W-1:0] base_d;
    logic [ADDR_W-1:0] len;
    logic [DATA_W-1:0] mem_rdata;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic              mem_store;
    logic              busy;
    logic              done;
    logic              carry_out;
    logic [2:0]        state_dbg;

    // master = controller plus memory; slave = the sequencer itself
    modport master (
        output start, op, base_a, base_b, base_d, len, mem_rdata,
        input  mem_addr, mem_wdata, mem_store, busy, done, carry_out, state_dbg
    );

    modport slave (
        input  start, op, base_a, base_b, base_d, len, mem_rdata,
        output mem_addr, mem_wdata, mem_store, busy, done, carry_out, state_dbg
    );
endinterface

// File: rtl/mem_arith_sequencer.sv
// Multi-byte little-endian add/subtract over the data memory: reads A[i], B[i], writes D[i],
// three cycles per byte, rippling carry (or inverted borrow) between bytes.
module mem_arith_sequencer #(
    parameter int ADDR_W = 8,
    parameter int DATA_W = 8
) (
    input logic                  clk,
    input logic                  rst,
    mem_arith_sequencer_if.slave bus
);

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_RD_A = 3'd1,
        S_RD_B = 3'd2,
        S_WR   = 3'd3,
        S_DONE = 3'd4
    } state_e;

    state_e            state_q, state_d;
    logic [ADDR_W-1:0] idx_q, idx_d;
    logic [ADDR_W-1:0] base_a_q, base_a_d;
    logic [ADDR_W-1:0] base_b_q, base_b_d;
    logic [ADDR_W-1:0] base_d_q, base_d_d;
    logic [ADDR_W-1:0] len_q, len_d;
    logic              op_q, op_d;
    logic              carry_q, carry_d;
    logic              carry_out_q, carry_out_d;
    logic [DATA_W-1:0] a_q, a_d;
    logic [DATA_W-1:0] b_q, b_d;

    logic [DATA_W:0]   sum;
    logic [ADDR_W-1:0] idx_inc;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic              mem_store;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= S_IDLE;
            idx_q       <= '0;
            base_a_q    <= '0;
            base_b_q    <= '0;
            base_d_q    <= '0;
            len_q       <= '0;
            op_q        <= 1'b0;
            carry_q     <= 1'b0;
            carry_out_q <= 1'b0;
            a_q         <= '0;
            b_q         <= '0;
        end else begin
            state_q     <= state_d;
            idx_q       <= idx_d;
            base_a_q    <= base_a_d;
            base_b_q    <= base_b_d;
            base_d_q    <= base_d_d;
            len_q       <= len_d;
            op_q        <= op_d;
            carry_q     <= carry_d;
            carry_out_q <= carry_out_d;
            a_q         <= a_d;
            b_q         <= b_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        idx_d       = idx_q;
        base_a_d    = base_a_q;
        base_b_d    = base_b_q;
        base_d_d    = base_d_q;
        len_d       = len_q;
        op_d        = op_q;
        carry_d     = carry_q;
        carry_out_d = carry_out_q;
        a_d         = a_q;
        b_d         = b_q;
        mem_addr    = '0;
        mem_wdata   = '0;
        mem_store   = 1'b0;

        // Subtract is A + ~B + 1, so the carry register starts at op and its final value is no-borrow.
        sum     = {1'b0, a_q} + {1'b0, (op_q ? ~b_q : b_q)} + {{DATA_W{1'b0}}, carry_q};
        idx_inc = idx_q + ADDR_W'(1);

        case (state_q)
            S_IDLE: begin
                if (bus.start) begin
                    op_d     = bus.op;
                    base_a_d = bus.base_a;
                    base_b_d = bus.base_b;
                    base_d_d = bus.base_d;
                    len_d    = bus.len;
                    idx_d    = '0;
                    carry_d  = bus.op;
                    if (bus.len != '0) begin
                        state_d     = S_RD_A;
                        carry_out_d = 1'b0;
                    end else begin
                        state_d     = S_DONE;
                        carry_out_d = bus.op;
                    end
                end
            end
            S_RD_A: begin
                mem_addr = base_a_q + idx_q;
                a_d      = bus.mem_rdata;
                state_d  = S_RD_B;
            end
            S_RD_B: begin
                mem_addr = base_b_q + idx_q;
                b_d      = bus.mem_rdata;
                state_d  = S_WR;
            end
            S_WR: begin
                mem_addr  = base_d_q + idx_q;
                mem_store = 1'b1;
                mem_wdata = sum[DATA_W-1:0];
                carry_d   = sum[DATA_W];
                idx_d     = idx_inc;
                if (idx_inc < len_q) begin
                    state_d = S_RD_A;
                end else begin
                    state_d     = S_DONE;
                    carry_out_d = sum[DATA_W];
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    assign bus.mem_addr  = mem_addr;
    assign bus.mem_wdata = mem_wdata;
    assign bus.mem_store = mem_store;
    assign bus.busy      = (state_q == S_RD_A) || (state_q == S_RD_B) || (state_q == S_WR);
    assign bus.done      = (state_q == S_DONE);
    assign bus.carry_out = carry_out_q;
    assign bus.state_dbg = state_q;

endmodule
